// File: rtl/bcd_alarm_clock_if.sv
// Pin bundle for bcd_alarm_clock: user controls in, display digits and status out.
// The master drives the controls; the slave (the clock core) drives the display.
interface bcd_alarm_clock_if;
  logic [3:0] key_n;
  logic       set_time;
  logic       set_alarm;
  logic       fmt_12h;
  logic       alarm_en;
  logic [3:0] hr_msd;
  logic [3:0] hr_lsd;
  logic [3:0] min_msd;
  logic [3:0] min_lsd;
  logic [5:0] sec;
  logic       pm;
  logic       blank;
  logic       alarm_active;
  logic       tick_cs;

  modport master (
    output key_n, set_time, set_alarm, fmt_12h, alarm_en,
    input  hr_msd, hr_lsd, min_msd, min_lsd, sec, pm, blank, alarm_active, tick_cs
  );

  modport slave (
    input  key_n, set_time, set_alarm, fmt_12h, alarm_en,
    output hr_msd, hr_lsd, min_msd, min_lsd, sec, pm, blank, alarm_active, tick_cs
  );
endinterface

// File: rtl/bcd_alarm_clock.sv
// 24-hour time-of-day clock with time/alarm set modes, key auto-repeat,
// 12/24-hour display and an alarm with timeout and dismiss.
module bcd_alarm_clock #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned HOLD_CS   = 50,
  parameter int unsigned REPEAT_CS = 10,
  parameter int unsigned ALARM_CS  = 6000
) (
  input logic              clk,
  input logic              reset,
  bcd_alarm_clock_if.slave bus
);
  localparam int unsigned DIV     = CLK_HZ / 100;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RPT_MAX = (HOLD_CS > REPEAT_CS) ? HOLD_CS : REPEAT_CS;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);
  localparam int unsigned AW      = $clog2(ALARM_CS + 1);

  localparam logic [PW-1:0] PreMax  = PW'(DIV - 1);
  localparam logic [RW-1:0] HoldMax = RW'(HOLD_CS - 1);
  localparam logic [RW-1:0] RptMax  = RW'(REPEAT_CS - 1);
  localparam logic [AW-1:0] AlmMax  = AW'(ALARM_CS - 1);

  localparam logic [1:0] StRun      = 2'd0;
  localparam logic [1:0] StSetTime  = 2'd1;
  localparam logic [1:0] StSetAlarm = 2'd2;

  logic [PW-1:0]        pre_q, pre_d;
  logic [6:0]           cs_q, cs_d;
  logic [5:0]           sec_q, sec_d;
  logic [5:0]           min_q, min_d;
  logic [4:0]           hr_q, hr_d;
  logic [5:0]           al_min_q, al_min_d;
  logic [4:0]           al_hr_q, al_hr_d;
  logic [1:0]           mode_q, mode_d;
  logic [3:0]           sync1_q, sync2_q, held_q;
  logic [3:0][RW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic [3:0]           rpt_on_q, rpt_on_d;
  logic                 alarm_q, alarm_d;
  logic [AW-1:0]        acnt_q, acnt_d;

  logic       tick;
  logic       mode_chg;
  logic [3:0] press;
  logic       carry;
  logic       trigger;

  function automatic logic [5:0] edit_min(logic [5:0] m, logic up, logic dn);
    if (up && !dn) return (m == 6'd59) ? 6'd0 : m + 6'd1;
    if (dn && !up) return (m == 6'd0) ? 6'd59 : m - 6'd1;
    return m;
  endfunction

  function automatic logic [4:0] edit_hr(logic [4:0] h, logic up, logic dn);
    if (up && !dn) return (h == 5'd23) ? 5'd0 : h + 5'd1;
    if (dn && !up) return (h == 5'd0) ? 5'd23 : h - 5'd1;
    return h;
  endfunction

  assign tick     = (pre_q == PreMax);
  assign mode_d   = bus.set_time ? StSetTime : (bus.set_alarm ? StSetAlarm : StRun);
  assign mode_chg = (mode_d != mode_q);
  assign pre_d    = tick ? '0 : pre_q + PW'(1);

  // Edge press plus hold/repeat presses, counted in centisecond ticks while held.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_on_d  = rpt_on_q;
    press     = held_q & ~sync2_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] || mode_chg) begin
        rpt_cnt_d[i] = '0;
        rpt_on_d[i]  = 1'b0;
      end else if (tick) begin
        if ((!rpt_on_q[i] && rpt_cnt_q[i] == HoldMax) ||
            (rpt_on_q[i] && rpt_cnt_q[i] == RptMax)) begin
          press[i]     = 1'b1;
          rpt_cnt_d[i] = '0;
          rpt_on_d[i]  = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
        end
      end
    end
  end

  always_comb begin
    cs_d     = cs_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    carry    = 1'b0;
    if (mode_q == StSetTime) begin
      cs_d  = '0;
      sec_d = '0;
      min_d = edit_min(min_q, press[1], press[0]);
      hr_d  = edit_hr(hr_q, press[3], press[2]);
    end else if (tick) begin
      if (cs_q == 7'd99) begin
        cs_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          carry = 1'b1;
          if (min_q == 6'd59) begin
            min_d = '0;
            hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        cs_d = cs_q + 7'd1;
      end
    end
    if (mode_q == StSetAlarm) begin
      al_min_d = edit_min(al_min_q, press[1], press[0]);
      al_hr_d  = edit_hr(al_hr_q, press[3], press[2]);
    end
  end

  // Only a counting minute carry can fire; edits never reach this path.
  assign trigger = carry && bus.alarm_en && (hr_d == al_hr_q) && (min_d == al_min_q);

  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (!bus.alarm_en) begin
      alarm_d = 1'b0;
    end else if (trigger) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (alarm_q) begin
      if (mode_q == StRun && |press) begin
        alarm_d = 1'b0;
      end else if (tick) begin
        if (acnt_q == AlmMax) alarm_d = 1'b0;
        else                  acnt_d  = acnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      cs_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      al_min_q  <= '0;
      al_hr_q   <= '0;
      mode_q    <= StRun;
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      held_q    <= 4'hF;
      rpt_cnt_q <= '0;
      rpt_on_q  <= '0;
      alarm_q   <= 1'b0;
      acnt_q    <= '0;
    end else begin
      pre_q     <= pre_d;
      cs_q      <= cs_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      al_min_q  <= al_min_d;
      al_hr_q   <= al_hr_d;
      mode_q    <= mode_d;
      sync1_q   <= bus.key_n;
      sync2_q   <= sync1_q;
      held_q    <= sync2_q;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_on_q  <= rpt_on_d;
      alarm_q   <= alarm_d;
      acnt_q    <= acnt_d;
    end
  end

  logic [4:0] disp_h, show_h;
  logic [5:0] disp_m;
  logic       pm_w;

  always_comb begin
    disp_h = (mode_q == StSetAlarm) ? al_hr_q : hr_q;
    disp_m = (mode_q == StSetAlarm) ? al_min_q : min_q;
    show_h = disp_h;
    pm_w   = 1'b0;
    if (bus.fmt_12h) begin
      if (disp_h == 5'd0) begin
        show_h = 5'd12;
      end else if (disp_h >= 5'd12) begin
        show_h = (disp_h == 5'd12) ? 5'd12 : disp_h - 5'd12;
        pm_w   = 1'b1;
      end
    end
  end

  assign bus.hr_msd       = 4'(show_h / 5'd10);
  assign bus.hr_lsd       = 4'(show_h % 5'd10);
  assign bus.min_msd      = 4'(disp_m / 6'd10);
  assign bus.min_lsd      = 4'(disp_m % 6'd10);
  assign bus.sec          = (mode_q == StSetAlarm) ? 6'd0 : sec_q;
  assign bus.pm           = pm_w;
  assign bus.blank        = (mode_q != StRun) && (cs_q < 7'd50);
  assign bus.alarm_active = alarm_q;
  assign bus.tick_cs      = tick;
endmodule
